// File: rtl/core_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_seq_pkg
// Description : Shared types and constants for the core_seq instruction
//               sequencer (state encoding, opcode/halt constants, fields).
// Revision    : 1.0 - initial release
// ============================================================================
package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_READ  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_WB    = 3'd5,
        ST_NEXT  = 3'd6,
        ST_HALT  = 3'd7
    } state_t;

    localparam logic [6:0]  OPC_OP_FP = 7'b1010011;
    localparam logic [31:0] HALT_INST = 32'h0000_0000;

    localparam int c_opc_lsb = 0;
    localparam int c_opc_msb = 6;
    localparam int c_rs1_lsb = 15;
    localparam int c_rs1_msb = 19;
    localparam int c_rs2_lsb = 20;
    localparam int c_rs2_msb = 24;

endpackage
`default_nettype wire

// File: rtl/core_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : core_seq_if
// Description : Core, instruction-memory and execution-unit signals seen by
//               the sequencer. master = sequencer, slave = core/environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_seq_if;
    logic        run;
    logic        halted;
    logic [31:0] instret;
    logic        pc_read;
    logic        pc_enable;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        rf_mode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        w_enable;
    logic        w_fmode;
    logic [4:0]  w_reg;
    logic [31:0] w_data;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_inst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_inst;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic        ex_done;
    logic [31:0] ex_result;
    logic        ex_wb;
    logic        ex_wfmode;
    logic [4:0]  ex_rd;
    logic        ex_branch;
    logic [31:0] ex_target;

    modport master (
        input  run, pc, rdata1, rdata2, if_ack, if_inst, ex_ready, ex_done,
               ex_result, ex_wb, ex_wfmode, ex_rd, ex_branch, ex_target,
        output halted, instret, pc_read, pc_enable, next_pc, rf_mode, rs1, rs2,
               w_enable, w_fmode, w_reg, w_data, if_req, if_addr, ex_valid,
               ex_inst, ex_op1, ex_op2
    );

    modport slave (
        output run, pc, rdata1, rdata2, if_ack, if_inst, ex_ready, ex_done,
               ex_result, ex_wb, ex_wfmode, ex_rd, ex_branch, ex_target,
        input  halted, instret, pc_read, pc_enable, next_pc, rf_mode, rs1, rs2,
               w_enable, w_fmode, w_reg, w_data, if_req, if_addr, ex_valid,
               ex_inst, ex_op1, ex_op2
    );
endinterface
`default_nettype wire

// File: rtl/core_seq_decode.sv
`default_nettype none
// ============================================================================
// Module      : core_seq_decode
// Description : Combinational decode of a fetched instruction into register
//               read addresses, operand bank select and halt detection.
// Revision    : 1.0 - initial release
// ============================================================================
module core_seq_decode
    import core_seq_pkg::*;
(
    input  wire logic [31:0] inst,
    output logic      [4:0]  rs1,
    output logic      [4:0]  rs2,
    output logic             rf_mode,
    output logic             is_halt
);

    assign rs1     = inst[c_rs1_msb:c_rs1_lsb];
    assign rs2     = inst[c_rs2_msb:c_rs2_lsb];
    assign rf_mode = (inst[c_opc_msb:c_opc_lsb] == OPC_OP_FP);
    assign is_halt = (inst == HALT_INST);

endmodule
`default_nettype wire

// File: rtl/core_seq.sv
`default_nettype none
// ============================================================================
// Module      : core_seq
// Description : Multi-cycle sequencer: fetch, operand read, execute handshake,
//               writeback, PC advance. CORE_SEQ_STEP_EN adds single-step issue.
// Revision    : 1.0 - initial release
// ============================================================================
module core_seq
    import core_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic clk,
    input  wire logic rst,
`ifdef CORE_SEQ_STEP_EN
    input  wire logic step,
`endif
    core_seq_if.master bus
);

    state_t      r_state;
    logic        r_halted;
    logic [31:0] r_instret;
    logic        r_pc_read;
    logic        r_pc_enable;
    logic [31:0] r_next_pc;
    logic        r_rf_mode;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic        r_w_enable;
    logic        r_w_fmode;
    logic [4:0]  r_w_reg;
    logic [31:0] r_w_data;
    logic        r_if_req;
    logic [31:0] r_if_addr;
    logic        r_ex_valid;
    logic [31:0] r_ex_inst;
    logic [31:0] r_ex_op1;
    logic [31:0] r_ex_op2;
    logic        r_branch;
    logic [31:0] r_target;

    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_rf_mode;
    logic        w_is_halt;
    logic        w_start;
    logic        w_continue;
    logic        w_unused_reset_pc;

    // The PC lives in the core; this value is documentation only.
    assign w_unused_reset_pc = ^RESET_PC;

`ifdef CORE_SEQ_STEP_EN
    assign w_start    = bus.run & step;
    assign w_continue = 1'b0;
`else
    assign w_start    = bus.run;
    assign w_continue = bus.run;
`endif

    core_seq_decode u_decode (
        .inst    (bus.if_inst),
        .rs1     (w_rs1),
        .rs2     (w_rs2),
        .rf_mode (w_rf_mode),
        .is_halt (w_is_halt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_halted    <= 1'b0;
            r_instret   <= 32'd0;
            r_pc_read   <= 1'b0;
            r_pc_enable <= 1'b0;
            r_next_pc   <= 32'd0;
            r_rf_mode   <= 1'b0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_w_enable  <= 1'b0;
            r_w_fmode   <= 1'b0;
            r_w_reg     <= 5'd0;
            r_w_data    <= 32'd0;
            r_if_req    <= 1'b0;
            r_if_addr   <= 32'd0;
            r_ex_valid  <= 1'b0;
            r_ex_inst   <= 32'd0;
            r_ex_op1    <= 32'd0;
            r_ex_op2    <= 32'd0;
            r_branch    <= 1'b0;
            r_target    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_FETCH;
                        r_pc_read <= 1'b1;
                        r_if_req  <= 1'b1;
                        r_if_addr <= bus.pc;
                    end
                end
                ST_FETCH: begin
                    if (bus.if_ack) begin
                        r_pc_read <= 1'b0;
                        r_if_req  <= 1'b0;
                        if (w_is_halt) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state   <= ST_READ;
                            r_ex_inst <= bus.if_inst;
                            r_rs1     <= w_rs1;
                            r_rs2     <= w_rs2;
                            r_rf_mode <= w_rf_mode;
                        end
                    end
                end
                ST_READ: begin
                    r_state    <= ST_EXEC;
                    r_ex_valid <= 1'b1;
                    r_ex_op1   <= bus.rdata1;
                    r_ex_op2   <= bus.rdata2;
                end
                ST_EXEC: begin
                    if (bus.ex_ready) begin
                        r_state    <= ST_WAIT;
                        r_ex_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus.ex_done) begin
                        r_state    <= ST_WB;
                        // Integer x0 is hardwired zero; float f0 is a real register.
                        r_w_enable <= bus.ex_wb & ~((bus.ex_rd == 5'd0) & ~bus.ex_wfmode);
                        r_w_reg    <= bus.ex_rd;
                        r_w_data   <= bus.ex_result;
                        r_w_fmode  <= bus.ex_wfmode;
                        r_branch   <= bus.ex_branch;
                        r_target   <= bus.ex_target;
                    end
                end
                ST_WB: begin
                    r_state     <= ST_NEXT;
                    r_w_enable  <= 1'b0;
                    r_pc_enable <= 1'b1;
                    r_next_pc   <= r_branch ? r_target : bus.pc + 32'd4;
                end
                ST_NEXT: begin
                    r_pc_enable <= 1'b0;
                    r_instret   <= r_instret + 32'd1;
                    if (w_continue) begin
                        // Core loads next_pc at this edge, so fetch from it directly.
                        r_state   <= ST_FETCH;
                        r_pc_read <= 1'b1;
                        r_if_req  <= 1'b1;
                        r_if_addr <= r_next_pc;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.halted    = r_halted;
    assign bus.instret   = r_instret;
    assign bus.pc_read   = r_pc_read;
    assign bus.pc_enable = r_pc_enable;
    assign bus.next_pc   = r_next_pc;
    assign bus.rf_mode   = r_rf_mode;
    assign bus.rs1       = r_rs1;
    assign bus.rs2       = r_rs2;
    assign bus.w_enable  = r_w_enable;
    assign bus.w_fmode   = r_w_fmode;
    assign bus.w_reg     = r_w_reg;
    assign bus.w_data    = r_w_data;
    assign bus.if_req    = r_if_req;
    assign bus.if_addr   = r_if_addr;
    assign bus.ex_valid  = r_ex_valid;
    assign bus.ex_inst   = r_ex_inst;
    assign bus.ex_op1    = r_ex_op1;
    assign bus.ex_op2    = r_ex_op2;

endmodule
`default_nettype wire

// File: tb/tb_core_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_seq
// Description : Directed self-checking bench for core_seq with a small core,
//               instruction-memory and execution-unit environment.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_seq;

    localparam logic [31:0] c_inst_int = 32'h0053_81B3; // rs1=7 rs2=5 opcode 0x33
    localparam logic [31:0] c_inst_fp  = 32'h0091_0053; // rs1=2 rs2=9 opcode OP-FP

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef CORE_SEQ_STEP_EN
    logic step = 1'b0;
`endif
    always #5 clk = ~clk;

    core_seq_if bus();

    core_seq #(.RESET_PC(32'h0000_0000)) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef CORE_SEQ_STEP_EN
        .step (step),
`endif
        .bus  (bus)
    );

    // Register file returns a value tagged by bank and register number.
    assign bus.rdata1 = 32'hA000_0000 | {23'd0, bus.rf_mode, 3'd0, bus.rs1};
    assign bus.rdata2 = 32'hB000_0000 | {23'd0, bus.rf_mode, 3'd0, bus.rs2};

    int checks = 0;
    int errors = 0;

    logic [31:0] inst_val = 32'd0;
    logic [31:0] cfg_result = 32'd0, cfg_target = 32'd0;
    logic [4:0]  cfg_rd = 5'd0;
    logic        cfg_wb = 1'b0, cfg_wfmode = 1'b0, cfg_branch = 1'b0;
    int          if_delay = 0, ex_delay = 0;
    bit          done_hold = 1'b0;
    int          inj_req = 0, inj_ack = 0;
    logic [31:0] pc_set_val = 32'd0;
    int          pc_set_req = 0, pc_set_ack = 0;

    int          wen_cnt = 0, pce_cnt = 0, overlap_cnt = 0, stab_err = 0;
    int          if_wait = 0, ex_wait = 0;
    bit          acc_pend = 1'b0;
    logic [31:0] last_w_data = 32'd0, last_next_pc = 32'd0, fetch_addr = 32'd0;
    logic [31:0] ex_inst_seen = 32'd0, op1_seen = 32'd0, op2_seen = 32'd0;
    logic [4:0]  last_w_reg = 5'd0;
    logic        last_w_fmode = 1'b0;

    // Environment: core PC register, instruction memory, execution unit, monitors.
    initial begin
        bus.run = 1'b0; bus.pc = 32'd0; bus.if_ack = 1'b0; bus.if_inst = 32'd0;
        bus.ex_ready = 1'b0; bus.ex_done = 1'b0; bus.ex_result = 32'd0;
        bus.ex_wb = 1'b0; bus.ex_wfmode = 1'b0; bus.ex_rd = 5'd0;
        bus.ex_branch = 1'b0; bus.ex_target = 32'd0;
        forever begin
            @(negedge clk);
            if (pc_set_req != pc_set_ack) begin
                bus.pc = pc_set_val;
                pc_set_ack = pc_set_req;
            end else if (bus.pc_enable === 1'b1) begin
                bus.pc = bus.next_pc;
            end
            if (bus.w_enable === 1'b1) begin
                wen_cnt++;
                last_w_reg = bus.w_reg; last_w_data = bus.w_data; last_w_fmode = bus.w_fmode;
            end
            if (bus.pc_enable === 1'b1) begin
                pce_cnt++;
                last_next_pc = bus.next_pc;
            end
            if (bus.w_enable === 1'b1 && bus.pc_enable === 1'b1) overlap_cnt++;
            if (bus.if_req === 1'b1) begin
                if (if_wait == 0) fetch_addr = bus.if_addr;
                else if (bus.if_addr !== fetch_addr || bus.pc_read !== 1'b1) stab_err++;
                bus.if_ack  = (if_wait >= if_delay);
                bus.if_inst = inst_val;
                if_wait++;
            end else begin
                bus.if_ack = 1'b0;
                if_wait = 0;
            end
            bus.ex_done = 1'b0;
            if (acc_pend && !done_hold) bus.ex_done = 1'b1;
            acc_pend = 1'b0;
            if (inj_req != inj_ack) begin
                bus.ex_done = 1'b1;
                inj_ack = inj_req;
            end
            bus.ex_result = cfg_result; bus.ex_wb = cfg_wb; bus.ex_wfmode = cfg_wfmode;
            bus.ex_rd = cfg_rd; bus.ex_branch = cfg_branch; bus.ex_target = cfg_target;
            if (bus.ex_valid === 1'b1) begin
                if (ex_wait == 0) begin
                    ex_inst_seen = bus.ex_inst; op1_seen = bus.ex_op1; op2_seen = bus.ex_op2;
                end else if (bus.ex_inst !== ex_inst_seen || bus.ex_op1 !== op1_seen ||
                             bus.ex_op2 !== op2_seen) begin
                    stab_err++;
                end
                bus.ex_ready = (ex_wait >= ex_delay);
                acc_pend = bus.ex_ready;
                ex_wait++;
            end else begin
                bus.ex_ready = 1'b0;
                ex_wait = 0;
            end
        end
    end

    task automatic set_pc(input logic [31:0] v);
        pc_set_val = v;
        pc_set_req++;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_ex(input logic [31:0] res, input logic [4:0] rd, input logic wb,
                          input logic wf, input logic br, input logic [31:0] tgt);
        cfg_result = res; cfg_rd = rd; cfg_wb = wb; cfg_wfmode = wf;
        cfg_branch = br; cfg_target = tgt;
    endtask

    // Issue one instruction; cyc counts FETCH through NEXT (or HALT entry).
    task automatic run_one(output int cyc);
        int n;
        n = 0;
        bus.run = 1'b1;
`ifdef CORE_SEQ_STEP_EN
        step = 1'b1;
`endif
        @(negedge clk);
`ifdef CORE_SEQ_STEP_EN
        step = 1'b0;
`endif
        while (bus.if_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        bus.run = 1'b0;
        cyc = 1;
        while (bus.pc_enable !== 1'b1 && bus.halted !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.run = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.halted, bus.pc_read, bus.pc_enable, bus.rf_mode, bus.w_enable,
             bus.w_fmode, bus.if_req, bus.ex_valid} !== 8'd0) begin
            errors++;
            $display("FAIL reset_strobes got %b want 00000000", {bus.halted, bus.pc_read,
                     bus.pc_enable, bus.rf_mode, bus.w_enable, bus.w_fmode, bus.if_req, bus.ex_valid});
        end
        checks++;
        if ({bus.instret, bus.next_pc, bus.if_addr, bus.w_data, bus.ex_inst, bus.ex_op1,
             bus.ex_op2, bus.rs1, bus.rs2, bus.w_reg} !== 239'd0) begin
            errors++;
            $display("FAIL reset_data got instret=%h next_pc=%h if_addr=%h w_data=%h want all 0",
                     bus.instret, bus.next_pc, bus.if_addr, bus.w_data);
        end
    endtask

    task automatic test_basic;
        int cyc;
        int w0;
        set_pc(32'h0000_0100);
        inst_val = c_inst_int; if_delay = 0; ex_delay = 0;
        set_ex(32'h55, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        w0 = wen_cnt;
        run_one(cyc);
        checks++;
        if (fetch_addr !== 32'h100) begin errors++; $display("FAIL basic_if_addr got %h want 00000100", fetch_addr); end
        checks++;
        if (cyc != 6) begin errors++; $display("FAIL basic_latency got %0d want 6", cyc); end
        checks++;
        if (wen_cnt - w0 != 1) begin errors++; $display("FAIL basic_w_enable_count got %0d want 1", wen_cnt - w0); end
        checks++;
        if (last_w_reg !== 5'd3 || last_w_data !== 32'h55 || last_w_fmode !== 1'b0) begin
            errors++;
            $display("FAIL basic_write got reg=%0d data=%h fmode=%b want reg=3 data=00000055 fmode=0",
                     last_w_reg, last_w_data, last_w_fmode);
        end
        checks++;
        if (last_next_pc !== 32'h104) begin errors++; $display("FAIL basic_next_pc got %h want 00000104", last_next_pc); end
        checks++;
        if (bus.instret !== 32'd1) begin errors++; $display("FAIL basic_instret got %0d want 1", bus.instret); end
        checks++;
        if (ex_inst_seen !== c_inst_int || op1_seen !== 32'hA000_0007 || op2_seen !== 32'hB000_0005) begin
            errors++;
            $display("FAIL basic_ex_payload got inst=%h op1=%h op2=%h want 005381b3 a0000007 b0000005",
                     ex_inst_seen, op1_seen, op2_seen);
        end
        checks++;
        if (bus.rs1 !== 5'd7 || bus.rs2 !== 5'd5 || bus.rf_mode !== 1'b0) begin
            errors++;
            $display("FAIL basic_decode got rs1=%0d rs2=%0d rf_mode=%b want 7 5 0", bus.rs1, bus.rs2, bus.rf_mode);
        end
    endtask

    task automatic test_x0_and_fmode;
        int cyc;
        int w0, p0;
        set_ex(32'h77, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        w0 = wen_cnt; p0 = pce_cnt;
        run_one(cyc);
        checks++;
        if (fetch_addr !== 32'h104) begin errors++; $display("FAIL x0_if_addr got %h want 00000104", fetch_addr); end
        checks++;
        if (wen_cnt - w0 != 0 || pce_cnt - p0 != 1) begin
            errors++;
            $display("FAIL x0_no_write got writes=%0d pc_updates=%0d want 0 1", wen_cnt - w0, pce_cnt - p0);
        end
        inst_val = c_inst_fp;
        set_ex(32'h3F80_0000, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0);
        w0 = wen_cnt;
        run_one(cyc);
        checks++;
        if (wen_cnt - w0 != 1 || last_w_fmode !== 1'b1 || last_w_reg !== 5'd0 || last_w_data !== 32'h3F80_0000) begin
            errors++;
            $display("FAIL f0_write got writes=%0d fmode=%b reg=%0d data=%h want 1 1 0 3f800000",
                     wen_cnt - w0, last_w_fmode, last_w_reg, last_w_data);
        end
        checks++;
        if (bus.rf_mode !== 1'b1 || op1_seen !== 32'hA000_0102 || op2_seen !== 32'hB000_0109) begin
            errors++;
            $display("FAIL fp_operands got rf_mode=%b op1=%h op2=%h want 1 a0000102 b0000109",
                     bus.rf_mode, op1_seen, op2_seen);
        end
    endtask

    task automatic test_pc_advance;
        int cyc;
        inst_val = c_inst_int;
        set_ex(32'h1, 5'd4, 1'b1, 1'b0, 1'b1, 32'h40);
        run_one(cyc);
        checks++;
        if (last_next_pc !== 32'h40) begin errors++; $display("FAIL branch_next_pc got %h want 00000040", last_next_pc); end
        set_pc(32'hFFFF_FFFC);
        set_ex(32'h2, 5'd4, 1'b1, 1'b0, 1'b0, 32'h40);
        run_one(cyc);
        checks++;
        if (fetch_addr !== 32'hFFFF_FFFC || last_next_pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next_pc got addr=%h next=%h want fffffffc 00000000", fetch_addr, last_next_pc);
        end
        checks++;
        if (bus.instret !== 32'd5) begin errors++; $display("FAIL pc_instret got %0d want 5", bus.instret); end
    endtask

    task automatic test_stall;
        int cyc;
        int s0;
        if_delay = 3; ex_delay = 2;
        s0 = stab_err;
        set_ex(32'h99, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0);
        run_one(cyc);
        checks++;
        if (cyc != 11) begin errors++; $display("FAIL stall_latency got %0d want 11", cyc); end
        checks++;
        if (stab_err != s0) begin errors++; $display("FAIL stall_stability got %0d changes want 0", stab_err - s0); end
        checks++;
        if (fetch_addr !== 32'h0 || op1_seen !== 32'hA000_0007 || op2_seen !== 32'hB000_0005 || last_w_data !== 32'h99) begin
            errors++;
            $display("FAIL stall_payload got addr=%h op1=%h op2=%h data=%h want 0 a0000007 b0000005 99",
                     fetch_addr, op1_seen, op2_seen, last_w_data);
        end
        if_delay = 0; ex_delay = 0;
    endtask

`ifndef CORE_SEQ_STEP_EN
    task automatic test_back_to_back;
        int n;
        logic [31:0] ir0;
        ir0 = bus.instret;
        set_ex(32'hAB, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0);
        bus.run = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.pc_enable !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (bus.if_req !== 1'b1 || bus.if_addr !== 32'h8) begin
            errors++;
            $display("FAIL b2b_fetch got if_req=%b if_addr=%h want 1 00000008", bus.if_req, bus.if_addr);
        end
        bus.run = 1'b0;
        n = 0;
        while (bus.pc_enable !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.instret !== ir0 + 32'd2 || last_next_pc !== 32'hC || bus.if_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_retire got instret=%0d next=%h if_req=%b want %0d 0000000c 0",
                     bus.instret, last_next_pc, bus.if_req, ir0 + 32'd2);
        end
    endtask
`endif

    task automatic test_halt;
        int cyc;
        int w0, p0;
        logic [31:0] ir0;
        ir0 = bus.instret; w0 = wen_cnt; p0 = pce_cnt;
        inst_val = 32'h0;
        run_one(cyc);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.halted !== 1'b1 || bus.if_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_state got halted=%b if_req=%b want 1 0", bus.halted, bus.if_req);
        end
        checks++;
        if (bus.instret !== ir0 || pce_cnt != p0 || wen_cnt != w0) begin
            errors++;
            $display("FAIL halt_side_effects got instret=%0d pc_updates=%0d writes=%0d want %0d 0 0",
                     bus.instret, pce_cnt - p0, wen_cnt - w0, ir0);
        end
        checks++;
        if (overlap_cnt != 0) begin errors++; $display("FAIL write_pc_overlap got %0d want 0", overlap_cnt); end
    endtask

    task automatic test_reset_in_wait;
        int n;
        int w0, p0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_pc(32'h200);
        inst_val = c_inst_int;
        set_ex(32'hDEAD, 5'd9, 1'b1, 1'b0, 1'b1, 32'h80);
        done_hold = 1'b1;
        w0 = wen_cnt; p0 = pce_cnt;
        bus.run = 1'b1;
        n = 0;
        while (bus.ex_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        bus.run = 1'b0;
        while (bus.ex_valid === 1'b1 && n < 50) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        inj_req++;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (wen_cnt != w0 || pce_cnt != p0) begin
            errors++;
            $display("FAIL rst_wait_effects got writes=%0d pc_updates=%0d want 0 0", wen_cnt - w0, pce_cnt - p0);
        end
        checks++;
        if ({bus.halted, bus.pc_read, bus.pc_enable, bus.w_enable, bus.if_req, bus.ex_valid} !== 6'd0 ||
            {bus.instret, bus.next_pc, bus.w_data, bus.ex_op1, bus.if_addr, bus.w_reg} !== 165'd0) begin
            errors++;
            $display("FAIL rst_wait_outputs got instret=%0d w_data=%h ex_op1=%h if_addr=%h w_enable=%b want all 0",
                     bus.instret, bus.w_data, bus.ex_op1, bus.if_addr, bus.w_enable);
        end
        done_hold = 1'b0;
    endtask

`ifdef CORE_SEQ_STEP_EN
    task automatic test_step;
        logic [31:0] ir0;
        ir0 = bus.instret;
        set_ex(32'h5, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0);
        bus.run = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.instret !== ir0 || bus.if_req !== 1'b0) begin
            errors++;
            $display("FAIL step_wait got instret=%0d if_req=%b want %0d 0", bus.instret, bus.if_req, ir0);
        end
        for (int k = 1; k <= 2; k++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (12) @(negedge clk);
            #1;
            checks++;
            if (bus.instret !== ir0 + k) begin
                errors++;
                $display("FAIL step_retire got %0d want %0d", bus.instret, ir0 + k);
            end
        end
        bus.run = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_x0_and_fmode();
        test_pc_advance();
        test_stall();
`ifndef CORE_SEQ_STEP_EN
        test_back_to_back();
`endif
        test_halt();
        test_reset_in_wait();
`ifdef CORE_SEQ_STEP_EN
        test_step();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_seq.md
# core_seq

Multi-cycle instruction sequencer that drives the core's PC and register-file port from the initiator side. Each instruction goes through the same steps: fetch, operand read, execute handshake, writeback, PC advance. The instruction memory and the execution unit connect through separate valid/ack handshakes. The sequencer sits between them and the core, and is the only writer of the core's PC and register file.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: informational only. The core owns the PC value; the sequencer never forces it.

Ports:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `run`  in  1  level; start or continue issuing instructions
- `halted`  out  1  high after the halt instruction; cleared only by `rst`
- `instret`  out  32  retired-instruction counter
- `pc_read`  out  1  PC read strobe to core
- `pc_enable`  out  1  PC update strobe to core
- `next_pc`  out  32  PC value to load on `pc_enable`
- `pc`  in  32  current PC from core
- `rf_mode`  out  1  operand bank select, 1 = float
- `rs1`  out  5  read register 1
- `rs2`  out  5  read register 2
- `rdata1`  in  32  read data 1 (combinational in core)
- `rdata2`  in  32  read data 2 (combinational in core)
- `w_enable`  out  1  register write strobe
- `w_fmode`  out  1  write bank select, 1 = float
- `w_reg`  out  5  write register
- `w_data`  out  32  write data
- `if_req`  out  1  fetch request
- `if_addr`  out  32  fetch address
- `if_ack`  in  1  fetch complete
- `if_inst`  in  32  fetched instruction
- `ex_valid`  out  1  execute request
- `ex_ready`  in  1  execution unit accepts request
- `ex_inst`  out  32  instruction for execution unit
- `ex_op1`  out  32  operand 1
- `ex_op2`  out  32  operand 2
- `ex_done`  in  1  result valid, 1-cycle pulse
- `ex_result`  in  32  result data
- `ex_wb`  in  1  result must be written back
- `ex_wfmode`  in  1  result bank select
- `ex_rd`  in  5  destination register
- `ex_branch`  in  1  take `ex_target`
- `ex_target`  in  32  branch/jump target
- `step`  in  1  present only under `CORE_SEQ_STEP_EN`

## Operation
States:
- **IDLE**: wait for `run` = 1, then go to FETCH.
- **FETCH**: hold `pc_read` = 1, `if_req` = 1, `if_addr` = `pc`.
  - On `if_ack`, latch `if_inst`.
  - If the latched value is 32'h0000_0000, go to HALT; otherwise go to READ.
- **READ** (1 cycle):
  - `rs1` = inst[19:15], `rs2` = inst[24:20].
  - `rf_mode` = 1 when inst[6:0] == 7'b1010011.
  - Latch `rdata1`/`rdata2` at the end of the cycle.
- **EXEC**: hold `ex_valid` = 1 with the latched inst and operands. Stable until `ex_ready`, then go to WAIT.
- **WAIT**: on `ex_done`, latch result, `ex_wb`, `ex_wfmode`, `ex_rd`, `ex_branch`, `ex_target`. Go to WB. `ex_done` is ignored in every other state.
- **WB** (1 cycle):
  - `w_enable` = `ex_wb` AND NOT (`ex_rd` == 0 AND `ex_wfmode` == 0). Integer x0 is never written.
  - `w_reg`, `w_data`, `w_fmode` come from the latched result.
- **NEXT** (1 cycle):
  - `pc_enable` = 1.
  - `next_pc` = `ex_target` if `ex_branch`, else `pc` + 4 (mod 2^32, wraps).
  - `instret` += 1 (wraps at 2^32).
  - Go to FETCH if `run` = 1, else IDLE.
- **HALT**: `halted` = 1. Terminal until `rst`. The halt instruction does not increment `instret` and does not move the PC.

Other rules:
- `run` falling is honoured only at the NEXT→IDLE decision. An instruction already in progress always completes.
- All strobes are 0 outside their states. Data outputs hold their last value.

## Timing
- Reset: every output is 0, state is IDLE, `instret` is 0. Reset in any state aborts the instruction: no write, no PC update, and a later `ex_done` is ignored.
- Minimum latency is 6 cycles per instruction (FETCH, READ, EXEC, WAIT, WB, NEXT). This assumes same-cycle `if_ack` and `ex_ready`, and `ex_done` in the cycle after acceptance.
- Back-to-back with `run` held high: FETCH of instruction n+1 follows NEXT of instruction n directly.
- The core sees at most one write and one PC update per instruction, always in separate cycles.

## Configuration
- `CORE_SEQ_STEP_EN` defined:
  - The `step` port exists.
  - After NEXT, go to IDLE regardless of `run`.
  - IDLE leaves only on a `step` pulse (with `run` = 1).
- Undefined: no `step` port; continuous issue as above.

## Structure
- `core_seq_pkg` holds:
  - state enum
  - `OPC_OP_FP` = 7'b1010011
  - `HALT_INST` = 32'h0
  - field bit positions
- Sub-module `core_seq_decode` is combinational: inst → `rs1`, `rs2`, `rf_mode`, `is_halt`.

## Test plan
- Reset then `run` = 1, `pc` = 0x100, instant acks, `ex_result` = 0x55, `ex_rd` = 3, `ex_wb` = 1 → `if_addr` = 0x100; `w_enable` pulse with `w_reg` = 3, `w_data` = 0x55; `next_pc` = 0x104; `instret` = 1; 6 cycles.
- `ex_rd` = 0, `ex_wfmode` = 0, `ex_wb` = 1 → no `w_enable`. Same with `ex_wfmode` = 1 → `w_enable` = 1 with `w_fmode` = 1.
- `ex_branch` = 1, `ex_target` = 0x40 → `next_pc` = 0x40. `pc` = 0xFFFF_FFFC without branch → `next_pc` = 0.
- `if_ack` delayed 3 cycles and `ex_ready` delayed 2 → `if_req`, `ex_valid`, `ex_op1`/`ex_op2` held stable throughout; operands equal `rdata` sampled in READ.
- `if_inst` = 0 → `halted` = 1, no `pc_enable`, `instret` unchanged. `rst` asserted in WAIT, then `ex_done` → no write, all outputs 0.
- `CORE_SEQ_STEP_EN` with `run` = 1 → exactly one instruction retired per `step` pulse.
